// File: rtl/rmii_rx_deframer.sv
// RMII receive deframer: strips preamble/SFD from CRS_DV/RXD dibits and
// assembles LSB-first payload bytes with SOF/EOF, length and error status.
module rmii_rx_deframer #(
    parameter int MIN_PREAMBLE_DIBITS = 4,
    parameter int MAX_FRAME_BYTES     = 1522,
    parameter int LEN_W               = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             crsdv,
    input  logic [1:0]       rxd,
    output logic [7:0]       byte_o,
    output logic             byte_valid_o,
    output logic             sof_o,
    output logic             eof_o,
    output logic             err_o,
    output logic [LEN_W-1:0] frame_len_o
);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    localparam logic [4:0]       PRE_MIN = 5'(MIN_PREAMBLE_DIBITS);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_FRAME_BYTES);

    state_t           state_q, state_d;
    logic [4:0]       pre_cnt_q, pre_cnt_d;
    logic [1:0]       dibit_idx_q, dibit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             first_q, first_d;
    logic [7:0]       byte_q, byte_d;
    logic             byte_valid_q, byte_valid_d;
    logic             sof_q, sof_d;
    logic             eof_q, eof_d;
    logic             err_q, err_d;
    logic [LEN_W-1:0] frame_len_q, frame_len_d;

    // State, counters and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pre_cnt_q    <= 5'd0;
            dibit_idx_q  <= 2'd0;
            shreg_q      <= 8'd0;
            len_q        <= {LEN_W{1'b0}};
            first_q      <= 1'b0;
            byte_q       <= 8'd0;
            byte_valid_q <= 1'b0;
            sof_q        <= 1'b0;
            eof_q        <= 1'b0;
            err_q        <= 1'b0;
            frame_len_q  <= {LEN_W{1'b0}};
        end else begin
            state_q      <= state_d;
            pre_cnt_q    <= pre_cnt_d;
            dibit_idx_q  <= dibit_idx_d;
            shreg_q      <= shreg_d;
            len_q        <= len_d;
            first_q      <= first_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            sof_q        <= sof_d;
            eof_q        <= eof_d;
            err_q        <= err_d;
            frame_len_q  <= frame_len_d;
        end
    end

    // Next-state and next-output logic; strobes default low every cycle
    always_comb begin
        state_d      = state_q;
        pre_cnt_d    = pre_cnt_q;
        dibit_idx_d  = dibit_idx_q;
        shreg_d      = shreg_q;
        len_d        = len_q;
        first_d      = first_q;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        sof_d        = 1'b0;
        eof_d        = 1'b0;
        err_d        = 1'b0;
        frame_len_d  = {LEN_W{1'b0}};

        case (state_q)
            IDLE: begin
                if (crsdv && (rxd == 2'b01)) begin
                    state_d   = PREAMBLE;
                    pre_cnt_d = 5'd1;
                end else begin
                    state_d   = IDLE;
                end
            end
            PREAMBLE: begin
                if (!crsdv) begin
                    state_d = IDLE;
                end else begin
                    case (rxd)
                        2'b01: begin
                            if (pre_cnt_q != 5'd31) begin
                                pre_cnt_d = pre_cnt_q + 5'd1;
                            end else begin
                                pre_cnt_d = pre_cnt_q;
                            end
                        end
                        2'b11: begin
                            if (pre_cnt_q >= PRE_MIN) begin
                                state_d     = DATA;
                                dibit_idx_d = 2'd0;
                                len_d       = {LEN_W{1'b0}};
                                first_d     = 1'b1;
                            end else begin
                                state_d     = DROP;
                            end
                        end
                        default: state_d = DROP;
                    endcase
                end
            end
            DATA: begin
                if (!crsdv) begin
                    // A partially received byte or an empty payload marks the frame bad
                    state_d     = IDLE;
                    eof_d       = 1'b1;
                    frame_len_d = len_q;
                    err_d       = (dibit_idx_q != 2'd0) || (len_q == {LEN_W{1'b0}});
                end else begin
                    shreg_d     = {rxd, shreg_q[7:2]};
                    dibit_idx_d = dibit_idx_q + 2'd1;
                    if (dibit_idx_q == 2'd3) begin
                        if (len_q == LEN_MAX) begin
                            state_d     = DROP;
                            eof_d       = 1'b1;
                            err_d       = 1'b1;
                            frame_len_d = LEN_MAX;
                        end else begin
                            byte_d       = {rxd, shreg_q[7:2]};
                            byte_valid_d = 1'b1;
                            sof_d        = first_q;
                            first_d      = 1'b0;
                            len_d        = len_q + {{(LEN_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        len_d = len_q;
                    end
                end
            end
            DROP: begin
                if (!crsdv) begin
                    state_d = IDLE;
                end else begin
                    state_d = DROP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = byte_valid_q;
    assign sof_o        = sof_q;
    assign eof_o        = eof_q;
    assign err_o        = err_q;
    assign frame_len_o  = frame_len_q;

endmodule

// File: tb/tb_rmii_rx_deframer.sv
// Randomized self-checking bench for rmii_rx_deframer: two instances (default
// and MAX_FRAME_BYTES=8) compared against a frame-level event model.
module tb_rmii_rx_deframer;

    localparam int MAX_A   = 1522;
    localparam int MAX_B   = 8;
    localparam int MIN_PRE = 4;

    typedef struct packed {
        int          cyc;
        logic        eof;
        logic [7:0]  data;
        logic        sof;
        logic        err;
        logic [10:0] len;
    } ev_t;

    logic        clk;
    logic        rst;
    logic        crsdv;
    logic [1:0]  rxd;
    logic [7:0]  byte_a, byte_b;
    logic        bv_a, bv_b, sof_a, sof_b, eof_a, eof_b, err_a, err_b;
    logic [10:0] len_a, len_b;

    int checks = 0;
    int errors = 0;
    int viol   = 0;
    int cyc    = 0;
    int base   = 0;

    logic [2:0] stim_q[$];
    logic [7:0] pay_q[$];
    ev_t        exp_a[$], exp_b[$], obs_a[$], obs_b[$];

    rmii_rx_deframer u_dut_a (
        .clk(clk), .rst(rst), .crsdv(crsdv), .rxd(rxd),
        .byte_o(byte_a), .byte_valid_o(bv_a), .sof_o(sof_a),
        .eof_o(eof_a), .err_o(err_a), .frame_len_o(len_a)
    );

    rmii_rx_deframer #(.MAX_FRAME_BYTES(MAX_B)) u_dut_b (
        .clk(clk), .rst(rst), .crsdv(crsdv), .rxd(rxd),
        .byte_o(byte_b), .byte_valid_o(bv_b), .sof_o(sof_b),
        .eof_o(eof_b), .err_o(err_b), .frame_len_o(len_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk_ev(input int c, input logic e, input logic [7:0] d,
                                  input logic s, input logic r, input int l);
        ev_t ev;
        ev.cyc = c; ev.eof = e; ev.data = d; ev.sof = s; ev.err = r; ev.len = 11'(l);
        return ev;
    endfunction

    // Output collector, plus protocol invariants recorded as a violation count
    always @(negedge clk) begin
        if (!rst) begin
            if (bv_a)  obs_a.push_back(mk_ev(cyc - base, 1'b0, byte_a, sof_a, 1'b0, 0));
            if (eof_a) obs_a.push_back(mk_ev(cyc - base, 1'b1, 8'd0, 1'b0, err_a, int'(len_a)));
            if (bv_b)  obs_b.push_back(mk_ev(cyc - base, 1'b0, byte_b, sof_b, 1'b0, 0));
            if (eof_b) obs_b.push_back(mk_ev(cyc - base, 1'b1, 8'd0, 1'b0, err_b, int'(len_b)));
            if ((bv_a && eof_a) || (!eof_a && (err_a || len_a != 11'd0)) || (sof_a && !bv_a)) viol++;
            if ((bv_b && eof_b) || (!eof_b && (err_b || len_b != 11'd0)) || (sof_b && !bv_b)) viol++;
        end
    end

    task automatic clear_all;
        stim_q.delete(); exp_a.delete(); exp_b.delete();
    endtask

    task automatic rand_payload(input int n);
        pay_q.delete();
        for (int k = 0; k < n; k++) pay_q.push_back(8'($urandom_range(255, 0)));
    endtask

    // Appends one frame's wire dibits and, from the frame rules, the events each DUT must produce.
    task automatic add_frame(input int junk, input int npre, input int nextra, input int gap);
        int s, e, n, m, nb;
        logic [7:0] b;
        ev_t ev;
        n = pay_q.size();
        repeat (junk) stim_q.push_back(3'b100);
        repeat (npre) stim_q.push_back(3'b101);
        s = stim_q.size();
        stim_q.push_back(3'b111);
        for (int k = 0; k < n; k++) begin
            b = pay_q[k];
            for (int d = 0; d < 4; d++) stim_q.push_back({1'b1, b[2*d +: 2]});
        end
        repeat (nextra) stim_q.push_back({1'b1, 2'($urandom_range(3, 0))});
        e = stim_q.size();
        repeat (gap) stim_q.push_back(3'b000);
        if (npre >= MIN_PRE) begin
            for (int d = 0; d < 2; d++) begin
                m  = (d == 0) ? MAX_A : MAX_B;
                nb = (n > m) ? m : n;
                for (int k = 0; k < nb; k++) begin
                    ev = mk_ev(s + 4*k + 5, 1'b0, pay_q[k], (k == 0), 1'b0, 0);
                    if (d == 0) exp_a.push_back(ev); else exp_b.push_back(ev);
                end
                if (n > m) ev = mk_ev(s + 4*m + 5, 1'b1, 8'd0, 1'b0, 1'b1, m);
                else       ev = mk_ev(e + 1, 1'b1, 8'd0, 1'b0, (nextra != 0) || (n == 0), n);
                if (d == 0) exp_a.push_back(ev); else exp_b.push_back(ev);
            end
        end
    endtask

    task automatic play(input int stop_at);
        @(negedge clk);
        obs_a.delete(); obs_b.delete();
        base = cyc;
        for (int i = 0; i < stim_q.size() && i != stop_at; i++) begin
            {crsdv, rxd} = stim_q[i];
            @(negedge clk);
        end
        if (stop_at < 0) begin
            crsdv = 1'b0; rxd = 2'b00;
            repeat (6) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if ({byte_a, bv_a, sof_a, eof_a, err_a, len_a} !== 23'd0) begin errors++; $display("FAIL reset A: got %h expected 0", {byte_a, bv_a, sof_a, eof_a, err_a, len_a}); end
        checks++; if ({byte_b, bv_b, sof_b, eof_b, err_b, len_b} !== 23'd0) begin errors++; $display("FAIL reset B: got %h expected 0", {byte_b, bv_b, sof_b, eof_b, err_b, len_b}); end
        rst = 1'b0;
    endtask

    task automatic test_nominal;
        clear_all();
        pay_q = '{8'h0D, 8'h0A, 8'h12, 8'h34};
        add_frame(0, 28, 0, 1);
        play(-1);
        checks++; if (obs_a.size() !== exp_a.size()) begin errors++; $display("FAIL nominal count A: got %0d expected %0d", obs_a.size(), exp_a.size()); end
        foreach (exp_a[i]) if (i < obs_a.size()) begin checks++; if (obs_a[i] !== exp_a[i]) begin errors++; $display("FAIL nominal event A[%0d]: got %h expected %h", i, obs_a[i], exp_a[i]); end end
        checks++; if (obs_b.size() !== exp_b.size()) begin errors++; $display("FAIL nominal count B: got %0d expected %0d", obs_b.size(), exp_b.size()); end
        foreach (exp_b[i]) if (i < obs_b.size()) begin checks++; if (obs_b[i] !== exp_b[i]) begin errors++; $display("FAIL nominal event B[%0d]: got %h expected %h", i, obs_b[i], exp_b[i]); end end
        checks++; if (viol !== 0) begin errors++; $display("FAIL nominal invariants: got %0d violations expected 0", viol); end
    endtask

    task automatic test_short_preamble;
        clear_all();
        rand_payload(4);
        add_frame(0, $urandom_range(3, 1), 0, 1);
        rand_payload(4);
        add_frame(0, $urandom_range(10, 4), 0, 1);
        play(-1);
        checks++; if (obs_a.size() !== exp_a.size()) begin errors++; $display("FAIL short_pre count A: got %0d expected %0d", obs_a.size(), exp_a.size()); end
        foreach (exp_a[i]) if (i < obs_a.size()) begin checks++; if (obs_a[i] !== exp_a[i]) begin errors++; $display("FAIL short_pre event A[%0d]: got %h expected %h", i, obs_a[i], exp_a[i]); end end
        checks++; if (obs_b.size() !== exp_b.size()) begin errors++; $display("FAIL short_pre count B: got %0d expected %0d", obs_b.size(), exp_b.size()); end
        foreach (exp_b[i]) if (i < obs_b.size()) begin checks++; if (obs_b[i] !== exp_b[i]) begin errors++; $display("FAIL short_pre event B[%0d]: got %h expected %h", i, obs_b[i], exp_b[i]); end end
        checks++; if (viol !== 0) begin errors++; $display("FAIL short_pre invariants: got %0d violations expected 0", viol); end
    endtask

    task automatic test_partial_byte;
        clear_all();
        rand_payload(2);
        add_frame(0, $urandom_range(20, 4), 2, 1);
        play(-1);
        checks++; if (obs_a.size() !== exp_a.size()) begin errors++; $display("FAIL partial count A: got %0d expected %0d", obs_a.size(), exp_a.size()); end
        foreach (exp_a[i]) if (i < obs_a.size()) begin checks++; if (obs_a[i] !== exp_a[i]) begin errors++; $display("FAIL partial event A[%0d]: got %h expected %h", i, obs_a[i], exp_a[i]); end end
        checks++; if (obs_b.size() !== exp_b.size()) begin errors++; $display("FAIL partial count B: got %0d expected %0d", obs_b.size(), exp_b.size()); end
        foreach (exp_b[i]) if (i < obs_b.size()) begin checks++; if (obs_b[i] !== exp_b[i]) begin errors++; $display("FAIL partial event B[%0d]: got %h expected %h", i, obs_b[i], exp_b[i]); end end
        checks++; if (viol !== 0) begin errors++; $display("FAIL partial invariants: got %0d violations expected 0", viol); end
    endtask

    task automatic test_overflow;
        clear_all();
        rand_payload(10);
        add_frame(0, 8, 0, 1);
        rand_payload(3);
        add_frame(0, 6, 0, 1);
        rand_payload(MAX_B);
        add_frame(0, 5, 0, 1);
        play(-1);
        checks++; if (obs_a.size() !== exp_a.size()) begin errors++; $display("FAIL overflow count A: got %0d expected %0d", obs_a.size(), exp_a.size()); end
        foreach (exp_a[i]) if (i < obs_a.size()) begin checks++; if (obs_a[i] !== exp_a[i]) begin errors++; $display("FAIL overflow event A[%0d]: got %h expected %h", i, obs_a[i], exp_a[i]); end end
        checks++; if (obs_b.size() !== exp_b.size()) begin errors++; $display("FAIL overflow count B: got %0d expected %0d", obs_b.size(), exp_b.size()); end
        foreach (exp_b[i]) if (i < obs_b.size()) begin checks++; if (obs_b[i] !== exp_b[i]) begin errors++; $display("FAIL overflow event B[%0d]: got %h expected %h", i, obs_b[i], exp_b[i]); end end
        checks++; if (viol !== 0) begin errors++; $display("FAIL overflow invariants: got %0d violations expected 0", viol); end
    endtask

    task automatic test_reset_mid_frame;
        clear_all();
        pay_q = '{8'h55, 8'hA3, 8'h3C, 8'hF0};
        add_frame(0, 28, 0, 1);
        play(38);
        #2 rst = 1'b1;
        #1;
        checks++; if ({byte_a, bv_a, sof_a, eof_a, err_a, len_a} !== 23'd0) begin errors++; $display("FAIL rst_mid outputs A: got %h expected 0", {byte_a, bv_a, sof_a, eof_a, err_a, len_a}); end
        checks++; if ({byte_b, bv_b, sof_b, eof_b, err_b, len_b} !== 23'd0) begin errors++; $display("FAIL rst_mid outputs B: got %h expected 0", {byte_b, bv_b, sof_b, eof_b, err_b, len_b}); end
        crsdv = 1'b0; rxd = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (obs_a.size() !== 2 || obs_a[obs_a.size()-1] !== exp_a[1]) begin errors++; $display("FAIL rst_mid pre-abort A: got %0d events expected 2 ending %h", obs_a.size(), exp_a[1]); end
        checks++; if (obs_b.size() !== 2 || obs_b[obs_b.size()-1] !== exp_b[1]) begin errors++; $display("FAIL rst_mid pre-abort B: got %0d events expected 2 ending %h", obs_b.size(), exp_b[1]); end
        clear_all();
        rand_payload(5);
        add_frame(0, 12, 0, 1);
        play(-1);
        checks++; if (obs_a.size() !== exp_a.size()) begin errors++; $display("FAIL rst_mid count A: got %0d expected %0d", obs_a.size(), exp_a.size()); end
        foreach (exp_a[i]) if (i < obs_a.size()) begin checks++; if (obs_a[i] !== exp_a[i]) begin errors++; $display("FAIL rst_mid event A[%0d]: got %h expected %h", i, obs_a[i], exp_a[i]); end end
        checks++; if (obs_b.size() !== exp_b.size()) begin errors++; $display("FAIL rst_mid count B: got %0d expected %0d", obs_b.size(), exp_b.size()); end
        foreach (exp_b[i]) if (i < obs_b.size()) begin checks++; if (obs_b[i] !== exp_b[i]) begin errors++; $display("FAIL rst_mid event B[%0d]: got %h expected %h", i, obs_b[i], exp_b[i]); end end
        checks++; if (viol !== 0) begin errors++; $display("FAIL rst_mid invariants: got %0d violations expected 0", viol); end
    endtask

    task automatic test_false_carrier_empty;
        clear_all();
        rand_payload(3);
        add_frame(10, $urandom_range(12, 4), 0, 1);
        pay_q.delete();
        add_frame(0, 6, 0, 1);
        play(-1);
        checks++; if (obs_a.size() !== exp_a.size()) begin errors++; $display("FAIL false_empty count A: got %0d expected %0d", obs_a.size(), exp_a.size()); end
        foreach (exp_a[i]) if (i < obs_a.size()) begin checks++; if (obs_a[i] !== exp_a[i]) begin errors++; $display("FAIL false_empty event A[%0d]: got %h expected %h", i, obs_a[i], exp_a[i]); end end
        checks++; if (obs_b.size() !== exp_b.size()) begin errors++; $display("FAIL false_empty count B: got %0d expected %0d", obs_b.size(), exp_b.size()); end
        foreach (exp_b[i]) if (i < obs_b.size()) begin checks++; if (obs_b[i] !== exp_b[i]) begin errors++; $display("FAIL false_empty event B[%0d]: got %h expected %h", i, obs_b[i], exp_b[i]); end end
        checks++; if (viol !== 0) begin errors++; $display("FAIL false_empty invariants: got %0d violations expected 0", viol); end
    endtask

    task automatic test_back_to_back;
        clear_all();
        for (int f = 0; f < 10; f++) begin
            rand_payload($urandom_range(12, 0));
            add_frame($urandom_range(2, 0), $urandom_range(40, 1), $urandom_range(3, 0), $urandom_range(3, 1));
        end
        play(-1);
        checks++; if (obs_a.size() !== exp_a.size()) begin errors++; $display("FAIL b2b count A: got %0d expected %0d", obs_a.size(), exp_a.size()); end
        foreach (exp_a[i]) if (i < obs_a.size()) begin checks++; if (obs_a[i] !== exp_a[i]) begin errors++; $display("FAIL b2b event A[%0d]: got %h expected %h", i, obs_a[i], exp_a[i]); end end
        checks++; if (obs_b.size() !== exp_b.size()) begin errors++; $display("FAIL b2b count B: got %0d expected %0d", obs_b.size(), exp_b.size()); end
        foreach (exp_b[i]) if (i < obs_b.size()) begin checks++; if (obs_b[i] !== exp_b[i]) begin errors++; $display("FAIL b2b event B[%0d]: got %h expected %h", i, obs_b[i], exp_b[i]); end end
        checks++; if (viol !== 0) begin errors++; $display("FAIL b2b invariants: got %0d violations expected 0", viol); end
    endtask

    initial begin
        rst   = 1'b1;
        crsdv = 1'b0;
        rxd   = 2'b00;
        test_reset();
        test_nominal();
        test_short_preamble();
        test_partial_byte();
        test_overflow();
        test_reset_mid_frame();
        test_false_carrier_empty();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rmii_rx_deframer.md
Name: rmii_rx_deframer

Overview:
- Front-end receive stage directly upstream of the MAC frame parser in the Ethernet debug link.
- Samples RMII CRS_DV and RXD dibits at 50 MHz and strips the preamble and SFD.
- Assembles payload dibits, LSB first, into bytes.
- Emits a byte stream with start-of-frame and end-of-frame markers, frame length and error status for the parser to consume.

Parameters:
- MIN_PREAMBLE_DIBITS, 4: minimum consecutive 01 dibits required before the SFD 11 dibit.
- MAX_FRAME_BYTES, 1522: byte count above which the frame is aborted with an error.
- LEN_W, 11: width of frame_len_o; must satisfy 2^LEN_W > MAX_FRAME_BYTES.

Ports:
- clk  input  1  RMII reference clock (50 MHz); all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- crsdv  input  1  RMII carrier sense / data valid.
- rxd  input  2  RMII receive dibit; bit 0 is the earlier bit on the wire.
- byte_o  output  8  assembled payload byte.
- byte_valid_o  output  1  one-cycle strobe; byte_o is valid.
- sof_o  output  1  high with byte_valid_o on the first payload byte of a frame.
- eof_o  output  1  one-cycle pulse marking the end of a frame; never coincident with byte_valid_o.
- err_o  output  1  valid only with eof_o; frame is bad.
- frame_len_o  output  LEN_W  payload bytes delivered in the frame; valid only with eof_o.

Behaviour:
- Reset is asynchronous and active-high. While rst is asserted, all outputs are 0, the FSM is in IDLE and all counters are cleared. Asserting rst mid-frame aborts the frame silently: no eof_o is produced.
- All outputs are registered.
- FSM states: IDLE, PREAMBLE, DATA, DROP.
- IDLE:
  - crsdv=1 and rxd=01 -> PREAMBLE, with pre_cnt=1.
  - crsdv=1 and rxd=00 (false carrier / PHY startup) -> stay in IDLE.
  - Any other value -> stay in IDLE.
- PREAMBLE:
  - crsdv=0 -> IDLE. No outputs.
  - rxd=01 -> pre_cnt++, saturating at 31.
  - rxd=11 and pre_cnt >= MIN_PREAMBLE_DIBITS -> DATA, with dibit_idx=0, len=0, first=1.
  - rxd=11 and pre_cnt < MIN_PREAMBLE_DIBITS -> DROP.
  - rxd=00 or 10 -> DROP.
- DATA, per cycle with crsdv=1:
  - Shift register updates as shreg <= {rxd, shreg[7:2]}; dibit_idx++ mod 4.
  - When dibit_idx==3, on the next cycle: byte_o={rxd, shreg[7:2]}, byte_valid_o=1, sof_o=first. Then first<=0 and len++.
  - Latency: the byte appears 1 cycle after its 4th dibit is sampled.
  - Byte cadence is exactly one byte_valid_o every 4 cycles.
- DATA overflow:
  - If a byte completes when len==MAX_FRAME_BYTES, that byte is not emitted.
  - The next cycle asserts eof_o=1, err_o=1, frame_len_o=MAX_FRAME_BYTES. FSM -> DROP.
- DATA end of frame (crsdv=0):
  - Next cycle: eof_o=1 and frame_len_o=len. FSM -> IDLE.
  - err_o=1 if dibit_idx!=0 (partial byte, discarded) or len==0. Otherwise err_o=0.
  - If the final byte completed on the previous cycle, its byte_valid_o occurs in the same cycle crsdv is seen low. eof_o then follows one cycle later, so byte_valid_o and eof_o never coincide.
  - RMII CRS_DV toggling at end of frame is not filtered: the first low sample ends the frame.
- DROP: wait for crsdv=0, then -> IDLE. No outputs.
- byte_valid_o, sof_o and eof_o are single-cycle pulses.
- err_o and frame_len_o are 0 whenever eof_o is 0.
- Back-to-back frames: crsdv low for 1 cycle between frames is sufficient to re-enter IDLE and accept a new preamble.

Test Plan:
- Nominal frame: crsdv=1; 28 dibits of 01, then 11; then payload bytes 0x0D,0x0A,0x12,0x34 LSB-dibit first; then crsdv=0 -> byte_valid_o at 4-cycle spacing with bytes 0x0D,0x0A,0x12,0x34; sof_o on 0x0D only; eof_o one cycle after crsdv falls with frame_len_o=4, err_o=0.
- Short preamble: 3 dibits of 01, then 11, then payload -> no byte_valid_o, no eof_o; a following valid frame after a 1-cycle crsdv gap decodes normally.
- Partial byte: valid preamble/SFD, 2 full bytes, then 2 extra dibits, then crsdv=0 -> 2 bytes emitted; eof_o with frame_len_o=2, err_o=1.
- Overflow: parameter override MAX_FRAME_BYTES=8; send a 10-byte payload -> exactly 8 byte_valid_o, then eof_o with err_o=1 and frame_len_o=8; no further output until crsdv drops and a new frame starts.
- Reset mid-frame: assert rst asynchronously (between clock edges) during byte 3 -> all outputs 0 immediately; no eof_o; the next full frame decodes with sof_o on its first byte.
- False carrier and empty frame: crsdv=1 with rxd=00 for 10 cycles, then a preamble -> frame is accepted. Separately, SFD followed immediately by crsdv=0 -> eof_o with frame_len_o=0, err_o=1.
